mp_regfile: RTL and testbench

MP_REGFILE -- requirements
Module: mp_regfile

---
 rtl/mp_regfile.sv | 109 ++++++++++
 tb/tb_mp_regfile.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mp_regfile.sv
// Multi-ported register file: 2 read, 2 write ports, pending scoreboard.
// Optional write trace when RF_TRACE_EN is defined.
module mp_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              rbusy1,
    output logic              rbusy2,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd0,
    input  logic [DATA_W-1:0] wd1,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic [31:0]       pc,
    output logic [ADDR_W:0]   pend_cnt
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};
    logic [DEPTH-1:0]  pend_q = '0;
    logic [DEPTH-1:0]  pend_d;

    logic w0_ok;
    logic w1_ok;

    logic [1:0][ADDR_W-1:0] ra_a;
    logic [1:0][DATA_W-1:0] rd_a;
    logic [1:0]             busy_a;

    // Port 0 loses a same-address collision with port 1.
    assign w1_ok = we1 && (wa1 != '0);
    assign w0_ok = we0 && (wa0 != '0) && !(we1 && (wa1 == wa0));

    assign ra_a[0] = ra1;
    assign ra_a[1] = ra2;
    assign rd1     = rd_a[0];
    assign rd2     = rd_a[1];
    assign rbusy1  = busy_a[0];
    assign rbusy2  = busy_a[1];

    always_comb begin
        rd_a   = '0;
        busy_a = '0;
        for (int p = 0; p < 2; p++) begin
            rd_a[p] = mem_q[ra_a[p]];
            if (we0 && (wa0 == ra_a[p])) rd_a[p] = wd0;
            if (we1 && (wa1 == ra_a[p])) rd_a[p] = wd1;
            busy_a[p] = pend_q[ra_a[p]]
                      && !(we0 && (wa0 == ra_a[p]))
                      && !(we1 && (wa1 == ra_a[p]));
            if (ra_a[p] == '0) begin
                rd_a[p]   = '0;
                busy_a[p] = 1'b0;
            end
        end
    end

    // Issue is applied after the write clears so a same-cycle set wins.
    always_comb begin
        pend_d = pend_q;
        if (we0) pend_d[wa0] = 1'b0;
        if (we1) pend_d[wa1] = 1'b0;
        if (iss_valid) pend_d[iss_addr] = 1'b1;
        pend_d[0] = 1'b0;
    end

    always_comb begin
        pend_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pend_cnt = pend_cnt + {{ADDR_W{1'b0}}, pend_q[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            pend_q <= '0;
        end else begin
            if (w0_ok) mem_q[wa0] <= wd0;
            if (w1_ok) mem_q[wa1] <= wd1;
            pend_q <= pend_d;
        end
    end

`ifdef RF_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w0_ok) $display("%0t@%h: $%0d <= %h", $time, pc, wa0, wd0);
            if (w1_ok) $display("%0t@%h: $%0d <= %h", $time, pc, wa1, wd1);
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^pc;
`endif

endmodule

// File: tb/tb_mp_regfile.sv
// Scoreboard bench for mp_regfile: directed scenarios plus random traffic.
module tb_mp_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  ra1, ra2, wa0, wa1, iss_addr;
    logic [31:0] rd1, rd2, wd0, wd1, pc;
    logic        rbusy1, rbusy2, we0, we1, iss_valid;
    logic [5:0]  pend_cnt;

    always #5 clk = ~clk;

    mp_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .reset(reset),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .rbusy1(rbusy1), .rbusy2(rbusy2),
        .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1),
        .wd0(wd0), .wd1(wd1),
        .iss_valid(iss_valid), .iss_addr(iss_addr),
        .pc(pc), .pend_cnt(pend_cnt)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, got, exp);
    endtask

    logic [31:0] m_mem [32];
    logic [31:0] m_pend;

    function automatic logic [31:0] m_rd(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (we1 && wa1 == a) return wd1;
        if (we0 && wa0 == a) return wd0;
        return m_mem[a];
    endfunction

    function automatic logic m_busy(input logic [4:0] a);
        if (a == 0) return 1'b0;
        if (we0 && wa0 == a) return 1'b0;
        if (we1 && wa1 == a) return 1'b0;
        return m_pend[a];
    endfunction

    task automatic model_edge();
        if (reset) begin
            for (int i = 0; i < 32; i++) m_mem[i] = '0;
            m_pend = '0;
        end else begin
            if (we0 && wa0 != 0) m_mem[wa0] = wd0;
            if (we1 && wa1 != 0) m_mem[wa1] = wd1;
            if (we0) m_pend[wa0] = 1'b0;
            if (we1) m_pend[wa1] = 1'b0;
            if (iss_valid && iss_addr != 0) m_pend[iss_addr] = 1'b1;
        end
    endtask

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sbq[$];

    task automatic push_exp(input string tag, input int sel,
                            input logic [31:0] e);
        exp_t x;
        x.tag = tag;
        x.sel = sel;
        x.exp = e;
        sbq.push_back(x);
    endtask

    task automatic step();
        exp_t        e;
        logic [31:0] obs;
        push_exp("rd1", 0, m_rd(ra1));
        push_exp("rd2", 1, m_rd(ra2));
        push_exp("rbusy1", 2, 32'(m_busy(ra1)));
        push_exp("rbusy2", 3, 32'(m_busy(ra2)));
        push_exp("pend_cnt", 4, 32'($countones(m_pend)));
        #1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            case (e.sel)
                0:       obs = rd1;
                1:       obs = rd2;
                2:       obs = 32'(rbusy1);
                3:       obs = 32'(rbusy2);
                default: obs = 32'(pend_cnt);
            endcase
            chk(e.tag, obs, e.exp);
        end
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; iss_valid = 0;
        wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0; iss_addr = 0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_mem[i] = '0;
        m_pend = '0;
        reset = 1; ra1 = 0; ra2 = 0; pc = 32'h1000;
        idle();
        @(negedge clk);
        step();
        reset = 0;

        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i);
            ra2 = 5'(31 - i);
            #1;
            chk("rst_rd1", rd1, 32'h0);
            chk("rst_busy1", 32'(rbusy1), 32'h0);
            chk("rst_cnt", 32'(pend_cnt), 32'h0);
            step();
        end

        we1 = 1; wa1 = 5; wd1 = 32'hDEADBEEF; ra1 = 5;
        #1 chk("byp5", rd1, 32'hDEADBEEF);
        step();
        idle(); ra1 = 5;
        #1 chk("st5", rd1, 32'hDEADBEEF);
        step();

        we0 = 1; wa0 = 7; wd0 = 1; we1 = 1; wa1 = 7; wd1 = 2;
        step();
        idle(); ra1 = 7;
        #1 chk("coll7", rd1, 32'h2);
        step();

        iss_valid = 1; iss_addr = 3;
        step();
        idle(); ra1 = 3;
        #1;
        chk("busy3", 32'(rbusy1), 32'h1);
        chk("cnt3", 32'(pend_cnt), 32'h1);
        step();
        we0 = 1; wa0 = 3; wd0 = 32'h33;
        #1 chk("busy3_wr", 32'(rbusy1), 32'h0);
        step();
        idle();
        #1 chk("cnt3_clr", 32'(pend_cnt), 32'h0);
        step();

        iss_valid = 1; iss_addr = 9; we1 = 1; wa1 = 9; wd1 = 55;
        step();
        idle(); ra1 = 9;
        #1;
        chk("rd9", rd1, 32'd55);
        chk("busy9", 32'(rbusy1), 32'h1);
        chk("cnt9", 32'(pend_cnt), 32'h1);
        step();

        we1 = 1; wa1 = 0; wd1 = 32'hFFFF; iss_valid = 1; iss_addr = 0;
        ra1 = 0;
        #1 chk("rd0_wr", rd1, 32'h0);
        step();
        idle(); ra1 = 0;
        #1;
        chk("rd0", rd1, 32'h0);
        chk("cnt0", 32'(pend_cnt), 32'h1);
        step();

        reset = 1; we1 = 1; wa1 = 4; wd1 = 32'hABCD; ra1 = 4;
        #1 chk("byp_rst", rd1, 32'hABCD);
        step();
        reset = 0; idle(); ra1 = 4;
        #1;
        chk("rd4_rst", rd1, 32'h0);
        chk("cnt_rst", 32'(pend_cnt), 32'h0);
        step();

        repeat (400) begin
            reset     = ($urandom_range(0, 40) == 0);
            we0       = 1'($urandom);
            we1       = 1'($urandom);
            wa0       = 5'($urandom_range(0, 7));
            wa1       = 5'($urandom_range(0, 7));
            wd0       = $urandom;
            wd1       = $urandom;
            iss_valid = 1'($urandom);
            iss_addr  = 5'($urandom_range(0, 7));
            ra1       = 5'($urandom_range(0, 7));
            ra2       = 5'($urandom_range(0, 7));
            pc        = $urandom;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
